// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: ALU op-code constants,
// decode-stage aluop encodings, R-type funct3 selects and the issue FSM states.
package alu_pkg;

  localparam logic [3:0] OP_AND    = 4'b0000;
  localparam logic [3:0] OP_OR     = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_SUB    = 4'b0110;
  localparam logic [3:0] OP_PASSB  = 4'b0111;
  localparam logic [3:0] OP_NOR    = 4'b1100;
  localparam logic [3:0] OP_NEGSUM = 4'b0101;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_NEGSUM = 3'b001;
  localparam logic [2:0] F3_NOR    = 3'b100;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of the decode-stage aluop/funct fields into the
// 4-bit ALU operation select. Undefined R-type encodings fall back to ADD
// and raise illegal so the requester can see the substitution.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b,
  output logic [3:0] op,
  output logic       illegal
);

  // Map aluop (and funct fields for R-type) onto an ALU op code.
  always_comb begin
    op      = OP_ADD;
    illegal = 1'b0;
    case (aluop)
      ALUOP_MEM:   op = OP_ADD;
      ALUOP_BR:    op = OP_SUB;
      ALUOP_PASSB: op = OP_PASSB;
      ALUOP_RTYPE: begin
        case (funct3)
          F3_ADDSUB: op = funct7b ? OP_SUB : OP_ADD;
          F3_AND:    op = OP_AND;
          F3_OR:     op = OP_OR;
          F3_NOR:    op = OP_NOR;
          F3_NEGSUM: op = OP_NEGSUM;
          default: begin
            op      = OP_ADD;
            illegal = 1'b1;
          end
        endcase
      end
      default: op = OP_ADD;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 64-bit combinational ALU. Accepts one request at a
// time, holds the ALU operands/op stable for EXEC and RESP, captures the ALU
// result at the end of EXEC and presents it with a locally computed zero flag.
// Optional build macro ALU_ISSUE_CHECK_EN adds a reference model and the
// chk_mismatch output, which flags an ALU result that disagrees with the model.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_aluop,
  input  logic [2:0]       req_funct3,
  input  logic             req_funct7b,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_illegal,
  output logic [TAG_W-1:0] rsp_tag
`ifdef ALU_ISSUE_CHECK_EN
  ,
  output logic             chk_mismatch
`endif
);

  state_e             state_q,   state_d;
  logic [WIDTH-1:0]   alu_a_q,   alu_a_d;
  logic [WIDTH-1:0]   alu_b_q,   alu_b_d;
  logic [3:0]         alu_op_q,  alu_op_d;
  logic [TAG_W-1:0]   tag_q,     tag_d;
  logic               illegal_q, illegal_d;
  logic [WIDTH-1:0]   result_q,  result_d;
  logic               zero_q,    zero_d;

  logic [3:0]         dec_op;
  logic               dec_illegal;
  logic               accept;

  alu_op_decode u_dec (
    .aluop   (req_aluop),
    .funct3  (req_funct3),
    .funct7b (req_funct7b),
    .op      (dec_op),
    .illegal (dec_illegal)
  );

  // req_ready is combinational in RESP so a new request can be taken in the
  // same cycle the response handshake completes.
  always_comb begin
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_RESP: req_ready = rsp_ready;
      default: req_ready = 1'b0;
    endcase
  end

  assign accept = req_valid & req_ready;

  // Next-state and next-register computation for the issue FSM.
  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    tag_d     = tag_q;
    illegal_d = illegal_q;
    result_d  = result_q;
    zero_d    = zero_q;

    // Operands and op move only on acceptance, keeping ALU inputs stable.
    if (accept) begin
      alu_a_d   = req_a;
      alu_b_d   = req_b;
      alu_op_d  = dec_op;
      tag_d     = req_tag;
      illegal_d = dec_illegal;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        result_d = alu_out;
        zero_d   = (alu_out == '0);
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = req_valid ? ST_EXEC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= OP_ADD;
      tag_q     <= '0;
      illegal_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      tag_q     <= tag_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_result  = result_q;
  assign rsp_zero    = zero_q;
  assign rsp_illegal = illegal_q;
  assign rsp_tag     = tag_q;

`ifdef ALU_ISSUE_CHECK_EN
  logic chk_q, chk_d;

  function automatic logic [WIDTH-1:0] alu_ref(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      OP_AND:    alu_ref = a & b;
      OP_OR:     alu_ref = a | b;
      OP_ADD:    alu_ref = a + b;
      OP_SUB:    alu_ref = a - b;
      OP_PASSB:  alu_ref = b;
      OP_NOR:    alu_ref = ~(a | b);
      OP_NEGSUM: alu_ref = '0 - a - b;
      default:   alu_ref = '0;
    endcase
  endfunction

  // Compare the ALU against the model while it settles in EXEC; the flag
  // registers at the same edge as the result, so it lines up with rsp_valid.
  always_comb begin
    chk_d = (state_q == ST_EXEC) && (alu_out != alu_ref(alu_op_q, alu_a_q, alu_b_q));
  end

  // Single-cycle mismatch pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chk_q <= 1'b0;
    else     chk_q <= chk_d;
  end

  assign chk_mismatch = chk_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural combinational ALU
// attached to the alu_* ports.
module tb_alu_issue_ctrl;

  localparam int WIDTH = 64;
  localparam int TAG_W = 4;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_aluop = 2'b00;
  logic [2:0]       req_funct3 = 3'b000;
  logic             req_funct7b = 1'b0;
  logic [WIDTH-1:0] req_a = '0;
  logic [WIDTH-1:0] req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_out;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_illegal;
  logic [TAG_W-1:0] rsp_tag;

  int checks = 0;
  int failures = 0;

  alu_issue_ctrl #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_aluop   (req_aluop),
    .req_funct3  (req_funct3),
    .req_funct7b (req_funct7b),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_tag     (req_tag),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_out     (alu_out),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_illegal (rsp_illegal),
    .rsp_tag     (rsp_tag)
  );

  always #5 clk = ~clk;

  // Behavioural ALU driven by the controller.
  always_comb begin
    case (alu_op)
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0010: alu_out = alu_a + alu_b;
      4'b0110: alu_out = alu_a - alu_b;
      4'b0111: alu_out = alu_b;
      4'b1100: alu_out = ~(alu_a | alu_b);
      4'b0101: alu_out = '0 - alu_a - alu_b;
      default: alu_out = '0;
    endcase
  end

  typedef struct {
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic        f7b;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [63:0] res;
    logic        zero;
    logic        ill;
  } vec_t;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [1:0] aluop, input logic [2:0] f3, input logic f7b,
                           input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag);
    req_valid   = 1'b1;
    req_aluop   = aluop;
    req_funct3  = f3;
    req_funct7b = f7b;
    req_a       = a;
    req_b       = b;
    req_tag     = tag;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
    checks++; if (alu_a !== 64'd0) begin failures++; $display("FAIL reset_alu_a got=%h exp=0", alu_a); end
    checks++; if (alu_b !== 64'd0) begin failures++; $display("FAIL reset_alu_b got=%h exp=0", alu_b); end
    checks++; if (alu_op !== 4'b0010) begin failures++; $display("FAIL reset_alu_op got=%b exp=0010", alu_op); end
    checks++; if (rsp_result !== 64'd0) begin failures++; $display("FAIL reset_rsp_result got=%h exp=0", rsp_result); end
    checks++; if (rsp_zero !== 1'b1) begin failures++; $display("FAIL reset_rsp_zero got=%0b exp=1", rsp_zero); end
    checks++; if (rsp_illegal !== 1'b0) begin failures++; $display("FAIL reset_rsp_illegal got=%0b exp=0", rsp_illegal); end
    checks++; if (rsp_tag !== 4'd0) begin failures++; $display("FAIL reset_rsp_tag got=%0d exp=0", rsp_tag); end
    rst = 1'b0;
    tick;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL idle_rsp_valid got=%0b exp=0", rsp_valid); end
  endtask

  // Each vector: accept in IDLE, EXEC after the first edge, RESP after the second.
  task automatic test_decode;
    vec_t tbl[12];
    tbl[0]  = '{2'b00, 3'b000, 1'b0, 64'd5,      64'd7,      4'b0010, 64'd12,    1'b0, 1'b0};
    tbl[1]  = '{2'b01, 3'b000, 1'b0, 64'h1234,   64'h1234,   4'b0110, 64'd0,     1'b1, 1'b0};
    tbl[2]  = '{2'b10, 3'b001, 1'b0, 64'd1,      64'd2,      4'b0101, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0};
    tbl[3]  = '{2'b10, 3'b100, 1'b0, 64'd0,      64'd0,      4'b1100, ONES,      1'b0, 1'b0};
    tbl[4]  = '{2'b10, 3'b010, 1'b0, 64'd3,      64'd4,      4'b0010, 64'd7,     1'b0, 1'b1};
    tbl[5]  = '{2'b10, 3'b111, 1'b1, 64'hF0F0,   64'hFF00,   4'b0000, 64'hF000,  1'b0, 1'b0};
    tbl[6]  = '{2'b10, 3'b110, 1'b0, 64'hF0F0,   64'h0F0F,   4'b0001, 64'hFFFF,  1'b0, 1'b0};
    tbl[7]  = '{2'b11, 3'b000, 1'b0, 64'd9,      64'hABCD,   4'b0111, 64'hABCD,  1'b0, 1'b0};
    tbl[8]  = '{2'b10, 3'b000, 1'b1, 64'd10,     64'd3,      4'b0110, 64'd7,     1'b0, 1'b0};
    tbl[9]  = '{2'b10, 3'b000, 1'b0, ONES,       64'd1,      4'b0010, 64'd0,     1'b1, 1'b0};
    tbl[10] = '{2'b10, 3'b000, 1'b1, 64'd0,      64'd1,      4'b0110, ONES,      1'b0, 1'b0};
    tbl[11] = '{2'b10, 3'b101, 1'b1, 64'd100,    64'd28,     4'b0010, 64'd128,   1'b0, 1'b1};
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic [3:0] tg;
      tg = 4'(i + 1);
      drive_req(tbl[i].aluop, tbl[i].f3, tbl[i].f7b, tbl[i].a, tbl[i].b, tg);
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL dec%0d_idle_ready got=%0b exp=1", i, req_ready); end
      tick;
      req_valid = 1'b0;
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL dec%0d_exec_valid got=%0b exp=0", i, rsp_valid); end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL dec%0d_exec_ready got=%0b exp=0", i, req_ready); end
      checks++; if (alu_op !== tbl[i].op) begin failures++; $display("FAIL dec%0d_alu_op got=%b exp=%b", i, alu_op, tbl[i].op); end
      checks++; if (alu_a !== tbl[i].a || alu_b !== tbl[i].b) begin failures++; $display("FAIL dec%0d_operands got=%h,%h exp=%h,%h", i, alu_a, alu_b, tbl[i].a, tbl[i].b); end
      tick;
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL dec%0d_rsp_valid got=%0b exp=1", i, rsp_valid); end
      checks++; if (rsp_result !== tbl[i].res) begin failures++; $display("FAIL dec%0d_result got=%h exp=%h", i, rsp_result, tbl[i].res); end
      checks++; if (rsp_zero !== tbl[i].zero) begin failures++; $display("FAIL dec%0d_zero got=%0b exp=%0b", i, rsp_zero, tbl[i].zero); end
      checks++; if (rsp_illegal !== tbl[i].ill) begin failures++; $display("FAIL dec%0d_illegal got=%0b exp=%0b", i, rsp_illegal, tbl[i].ill); end
      checks++; if (rsp_tag !== tg) begin failures++; $display("FAIL dec%0d_tag got=%0d exp=%0d", i, rsp_tag, tg); end
      tick;
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL dec%0d_back_idle got=%0b exp=0", i, rsp_valid); end
    end
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    drive_req(2'b00, 3'b000, 1'b0, 64'd5, 64'd7, 4'd1);
    tick;
    drive_req(2'b01, 3'b000, 1'b0, 64'd20, 64'd8, 4'd2);
    tick;
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp%0d_valid got=%0b exp=1", c, rsp_valid); end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp%0d_req_ready got=%0b exp=0", c, req_ready); end
      checks++; if (rsp_result !== 64'd12 || rsp_tag !== 4'd1) begin failures++; $display("FAIL bp%0d_hold got=%h/%0d exp=c/1", c, rsp_result, rsp_tag); end
      checks++; if (alu_op !== 4'b0010 || alu_a !== 64'd5) begin failures++; $display("FAIL bp%0d_alu_hold got=%b/%h exp=0010/5", c, alu_op, alu_a); end
      tick;
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_follows got=%0b exp=1", req_ready); end
    tick;
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_next_exec got=%0b exp=0", rsp_valid); end
    checks++; if (alu_op !== 4'b0110 || alu_a !== 64'd20) begin failures++; $display("FAIL bp_next_load got=%b/%h exp=0110/14", alu_op, alu_a); end
    tick;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_next_valid got=%0b exp=1", rsp_valid); end
    checks++; if (rsp_result !== 64'd12 || rsp_tag !== 4'd2) begin failures++; $display("FAIL bp_next_result got=%h/%0d exp=c/2", rsp_result, rsp_tag); end
    tick;
  endtask

  task automatic test_reset_exec;
    rsp_ready = 1'b1;
    drive_req(2'b00, 3'b000, 1'b0, 64'd100, 64'd23, 4'd5);
    tick;
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rx_valid got=%0b exp=0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rx_req_ready got=%0b exp=1", req_ready); end
    checks++; if (alu_a !== 64'd0 || alu_b !== 64'd0) begin failures++; $display("FAIL rx_operands got=%h,%h exp=0,0", alu_a, alu_b); end
    checks++; if (alu_op !== 4'b0010) begin failures++; $display("FAIL rx_alu_op got=%b exp=0010", alu_op); end
    checks++; if (rsp_result !== 64'd0 || rsp_zero !== 1'b1) begin failures++; $display("FAIL rx_result got=%h/%0b exp=0/1", rsp_result, rsp_zero); end
    checks++; if (rsp_tag !== 4'd0) begin failures++; $display("FAIL rx_tag got=%0d exp=0", rsp_tag); end
    @(negedge clk);
    rst = 1'b0;
    tick;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rx_lost got=%0b exp=0", rsp_valid); end
    drive_req(2'b00, 3'b000, 1'b0, 64'd2, 64'd3, 4'd6);
    tick;
    req_valid = 1'b0;
    tick;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rx_after_valid got=%0b exp=1", rsp_valid); end
    checks++; if (rsp_result !== 64'd5 || rsp_tag !== 4'd6) begin failures++; $display("FAIL rx_after_result got=%h/%0d exp=5/6", rsp_result, rsp_tag); end
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_decode;
    test_backpressure;
    test_reset_exec;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
